crc_dma_engine: RTL and testbench
=================================

Name: crc_dma_engine

Overview:
Parametrised successor to the single-burst crc3 engine. Software programs address, length, seed and mode over an Avalon-MM control slave. The block then streams memory through an Avalon-MM burst read master, computing a CRC over an arbitrary byte length, and raises a level irq on completion. It adds tail-byte masking, multi-burst transfers, a programmable seed, optional final XOR and abort.

Parameters:
DATA_WIDTH, 64, master data width in bits; multiple of 8; BYTES = DATA_WIDTH/8.
CRC_WIDTH, 32, CRC register width.
CRC_POLY, 32'h04C11DB7, generator polynomial, non-reflected, MSB-first.
CRC_INIT, 32'hFFFFFFFF, reset value of the SEED register.
MAX_BURST, 8, maximum beats per master burst.
BURST_WIDTH, 4, width of master_burstcount; must hold MAX_BURST.

Ports:
clk  in  1  single clock.
reset  in  1  synchronous, active-high.
ctrl_write  in  1  slave write strobe.
ctrl_read  in  1  slave read strobe.
ctrl_address  in  32  word address; only bits [2:0] decoded.
ctrl_writedata  in  32  slave write data.
ctrl_readdata  out  32  slave read data, fixed read latency 1.
ctrl_waitrequest  out  1  tied 0.
master_read  out  1  burst read request.
master_address  out  32  byte address of burst start.
master_burstcount  out  BURST_WIDTH  beats in burst.
master_byteenable  out  BYTES  constant all-ones.
master_readdata  in  DATA_WIDTH  read beat.
master_waitrequest  in  1  master stall.
master_readdatavalid  in  1  beat valid.
irq  out  1  level interrupt.

Behaviour:
- Registers (word address):
  - 0 CTRL: bit0 start (write-1 pulse, reads 0); bit1 irq_en; bit2 xorout_en (final XOR all-ones); bit3 abort (write-1 pulse).
  - 1 STATUS: bit0 busy (RO); bit1 done (W1C); bit2 error (W1C).
  - 2 ADDR: byte address.
  - 3 LENGTH: byte count.
  - 4 RESULT: RO.
  - 5 SEED: reset value CRC_INIT.
  - Unmapped addresses read 0.
- Reset: all outputs 0, all registers 0 except SEED=CRC_INIT, FSM in IDLE.
- While busy, writes to ADDR, LENGTH, SEED and start are ignored. Writes to irq_en and xorout_en always take effect.
- irq = (done | error) & irq_en, registered.
- FSM states: IDLE, REQ, DATA, DRAIN, FINISH.
- IDLE, on start:
  - If LENGTH==0 or ADDR[log2(BYTES)-1:0]!=0: done=1, error=1, RESULT = SEED (XORed if xorout_en); no master access; stay IDLE.
  - Otherwise load crc=SEED, beats_left=ceil(LENGTH/BYTES), bytes_left=LENGTH, cur_addr=ADDR; busy=1; go to REQ.
- REQ:
  - master_read=1, master_address=cur_addr, master_burstcount=min(MAX_BURST, beats_left).
  - Request is held stable while master_waitrequest=1.
  - On the cycle master_waitrequest=0: deassert master_read, load burst_left=burstcount, advance cur_addr by burstcount*BYTES; go to DATA.
- DATA (one burst outstanding at most):
  - Each master_readdatavalid consumes one beat. Bytes are processed byte 0 (bits 7:0) first, each byte MSB-first. Only min(BYTES, bytes_left) bytes enter the CRC.
  - Decrement beats_left, burst_left and bytes_left accordingly.
  - When burst_left reaches 0: go to REQ if beats_left>0, else FINISH.
- FINISH (1 cycle): RESULT = crc (XOR all-ones if xorout_en); done=1; busy=0; go to IDLE.
  - Latency: RESULT and done are visible the cycle after FINISH, i.e. 2 clocks after the final valid beat.
- Abort:
  - In REQ with the request not yet accepted: drop master_read immediately and go to IDLE.
  - In DATA: go to DRAIN and consume the remaining burst_left beats without CRC update, then IDLE.
  - In both cases error=1, done=0, busy=0, RESULT unchanged.
  - Abort in IDLE has no effect.
- master_readdatavalid in IDLE is ignored. This covers stray beats after a reset mid-transfer.
- A control write and an FSM status update in the same cycle: FSM set wins over W1C clear.
- CRC update per beat is a single-cycle combinational unroll of up to BYTES×8 bits.

Test Plan:
1. SEED=FFFFFFFF, xorout_en=0, ADDR=0x1000, LENGTH=9; memory holds ASCII "123456789". Required response: one request with burstcount=2; RESULT=0x0376E6E7; STATUS=0x2; irq=1 when irq_en=1.
2. Same as scenario 1 with xorout_en=1. Required response: RESULT=0xFC891918.
3. LENGTH=80, ADDR=0x2000, master_waitrequest held high 3 cycles on the first request. Required response: first request address 0x2000 with burstcount 8, held stable 4 cycles; second request address 0x2040 with burstcount 2; done after 10 beats.
4. LENGTH=0, start. Required response: no master_read asserted; STATUS=0x6; RESULT=SEED. Misaligned ADDR=0x1004 gives the same response.
5. LENGTH=64, abort written after the 3rd of 8 beats. Required response: 5 remaining beats drained; STATUS=0x4; RESULT unchanged; a new start then succeeds.
6. Reset asserted mid-DATA, followed by 2 stray readdatavalid beats. Required response: master_read=0, STATUS=0, SEED=FFFFFFFF, stray beats ignored; FSM stays IDLE.

Source files
------------

// File: rtl/crc_dma_engine.sv
// CRC DMA engine: register-programmed burst reads over Avalon-MM with a per-beat unrolled CRC update.
// RESULT/done are visible 2 clocks after the final beat; bursts stall on master_waitrequest; the slave never stalls.
module crc_dma_engine #(
    parameter int                   DATA_WIDTH  = 64,
    parameter int                   CRC_WIDTH   = 32,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY    = 32'h04C11DB7,
    parameter logic [CRC_WIDTH-1:0] CRC_INIT    = 32'hFFFFFFFF,
    parameter int                   MAX_BURST   = 8,
    parameter int                   BURST_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ctrl_write,
    input  logic                    ctrl_read,
    input  logic [31:0]             ctrl_address,
    input  logic [31:0]             ctrl_writedata,
    output logic [31:0]             ctrl_readdata,
    output logic                    ctrl_waitrequest,
    output logic                    master_read,
    output logic [31:0]             master_address,
    output logic [BURST_WIDTH-1:0]  master_burstcount,
    output logic [DATA_WIDTH/8-1:0] master_byteenable,
    input  logic [DATA_WIDTH-1:0]   master_readdata,
    input  logic                    master_waitrequest,
    input  logic                    master_readdatavalid,
    output logic                    irq
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(BYTES);

    typedef enum logic [2:0] {IDLE, REQ, DATA, DRAIN, FINISH} state_t;
    state_t state, state_next;

    logic                   irq_en, xorout_en, done, error;
    logic [31:0]            addr_reg, len_reg;
    logic [CRC_WIDTH-1:0]   result, seed, crc, crc_next;
    logic [31:0]            beats_left, bytes_left, cur_addr, take, beats_init;
    logic [BURST_WIDTH-1:0] burst_left, req_count;
    logic                   fb;

    logic wr_ctrl, wr_status, wr_addr, wr_len, wr_seed;
    logic start, abort, busy, start_bad, xor_eff, last_beat;
    logic unused_addr_bits;

    assign wr_ctrl   = ctrl_write && (ctrl_address[2:0] == 3'd0);
    assign wr_status = ctrl_write && (ctrl_address[2:0] == 3'd1);
    assign wr_addr   = ctrl_write && (ctrl_address[2:0] == 3'd2);
    assign wr_len    = ctrl_write && (ctrl_address[2:0] == 3'd3);
    assign wr_seed   = ctrl_write && (ctrl_address[2:0] == 3'd5);
    assign start     = wr_ctrl && ctrl_writedata[0];
    assign abort     = wr_ctrl && ctrl_writedata[3];
    assign unused_addr_bits = ^ctrl_address[31:3];

    // DRAIN only swallows beats of an aborted burst, so software already sees the block as idle.
    assign busy      = (state == REQ) || (state == DATA) || (state == FINISH);
    assign start_bad = (len_reg == 32'd0) || ((addr_reg & 32'(BYTES - 1)) != 32'd0);
    // A start written together with a new xorout_en must use the new value.
    assign xor_eff   = wr_ctrl ? ctrl_writedata[2] : xorout_en;
    assign last_beat = master_readdatavalid && (burst_left == BURST_WIDTH'(1));

    assign take       = (bytes_left > 32'(BYTES)) ? 32'(BYTES) : bytes_left;
    assign req_count  = (beats_left > 32'(MAX_BURST)) ? BURST_WIDTH'(MAX_BURST)
                                                      : beats_left[BURST_WIDTH-1:0];
    assign beats_init = 32'((33'(len_reg) + 33'(BYTES - 1)) >> SHIFT);

    assign ctrl_waitrequest  = 1'b0;
    assign master_byteenable = '1;

    // Byte 0 enters first, each byte MSB-first; tail bytes past bytes_left are skipped.
    always_comb begin
        crc_next = crc;
        fb       = 1'b0;
        for (int b = 0; b < BYTES; b++) begin
            if (32'(b) < take) begin
                for (int i = 7; i >= 0; i--) begin
                    fb       = crc_next[CRC_WIDTH-1] ^ master_readdata[b*8+i];
                    crc_next = {crc_next[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
                end
            end
        end
    end

    always_comb begin
        state_next        = state;
        master_read       = 1'b0;
        master_address    = '0;
        master_burstcount = '0;
        case (state)
            IDLE: begin
                if (start && !start_bad) state_next = REQ;
            end
            REQ: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    master_read       = 1'b1;
                    master_address    = cur_addr;
                    master_burstcount = req_count;
                    if (!master_waitrequest) state_next = DATA;
                end
            end
            DATA: begin
                if (abort)
                    state_next = last_beat ? IDLE : DRAIN;
                else if (last_beat)
                    state_next = (beats_left > 32'd1) ? REQ : FINISH;
            end
            DRAIN: begin
                if (last_beat) state_next = IDLE;
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            irq        <= 1'b0;
            irq_en     <= 1'b0;
            xorout_en  <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            addr_reg   <= '0;
            len_reg    <= '0;
            result     <= '0;
            seed       <= CRC_INIT;
            crc        <= '0;
            beats_left <= '0;
            bytes_left <= '0;
            cur_addr   <= '0;
            burst_left <= '0;
        end else begin
            state <= state_next;
            irq   <= (done | error) & irq_en;
            if (wr_ctrl) begin
                irq_en    <= ctrl_writedata[1];
                xorout_en <= ctrl_writedata[2];
            end
            if (wr_status) begin
                if (ctrl_writedata[1]) done  <= 1'b0;
                if (ctrl_writedata[2]) error <= 1'b0;
            end
            if (!busy) begin
                if (wr_addr) addr_reg <= ctrl_writedata;
                if (wr_len)  len_reg  <= ctrl_writedata;
                if (wr_seed) seed     <= CRC_WIDTH'(ctrl_writedata);
            end
            // Status sets below come after the W1C clears so the FSM wins a same-cycle race.
            case (state)
                IDLE: begin
                    if (start && start_bad) begin
                        done   <= 1'b1;
                        error  <= 1'b1;
                        result <= seed ^ (xor_eff ? '1 : '0);
                    end else if (start) begin
                        done       <= 1'b0;
                        error      <= 1'b0;
                        crc        <= seed;
                        beats_left <= beats_init;
                        bytes_left <= len_reg;
                        cur_addr   <= addr_reg;
                    end
                end
                REQ: begin
                    if (abort) begin
                        error <= 1'b1;
                        done  <= 1'b0;
                    end else if (!master_waitrequest) begin
                        burst_left <= req_count;
                        cur_addr   <= cur_addr + (32'(req_count) << SHIFT);
                    end
                end
                DATA: begin
                    if (abort) begin
                        error <= 1'b1;
                        done  <= 1'b0;
                        if (master_readdatavalid) burst_left <= burst_left - 1'b1;
                    end else if (master_readdatavalid) begin
                        crc        <= crc_next;
                        beats_left <= beats_left - 32'd1;
                        burst_left <= burst_left - 1'b1;
                        bytes_left <= bytes_left - take;
                    end
                end
                DRAIN: begin
                    if (master_readdatavalid) burst_left <= burst_left - 1'b1;
                end
                FINISH: begin
                    result <= crc ^ (xorout_en ? '1 : '0);
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_readdata <= '0;
        end else if (ctrl_read) begin
            case (ctrl_address[2:0])
                3'd0:    ctrl_readdata <= {29'd0, xorout_en, irq_en, 1'b0};
                3'd1:    ctrl_readdata <= {29'd0, error, done, busy};
                3'd2:    ctrl_readdata <= addr_reg;
                3'd3:    ctrl_readdata <= len_reg;
                3'd4:    ctrl_readdata <= 32'(result);
                3'd5:    ctrl_readdata <= 32'(seed);
                default: ctrl_readdata <= '0;
            endcase
        end else begin
            ctrl_readdata <= '0;
        end
    end
endmodule

// File: tb/tb_crc_dma_engine.sv
// Directed bench for crc_dma_engine: a burst memory responder plus register-level scenarios.
module tb_crc_dma_engine;
    logic        clk = 1'b0;
    logic        reset;
    logic        ctrl_write, ctrl_read;
    logic [31:0] ctrl_address, ctrl_writedata, ctrl_readdata;
    logic        ctrl_waitrequest;
    logic        master_read;
    logic [31:0] master_address;
    logic [3:0]  master_burstcount;
    logic [7:0]  master_byteenable;
    logic [63:0] master_readdata;
    logic        master_waitrequest, master_readdatavalid;
    logic        irq;

    always #5 clk = ~clk;

    crc_dma_engine dut (
        .clk(clk), .reset(reset),
        .ctrl_write(ctrl_write), .ctrl_read(ctrl_read), .ctrl_address(ctrl_address),
        .ctrl_writedata(ctrl_writedata), .ctrl_readdata(ctrl_readdata),
        .ctrl_waitrequest(ctrl_waitrequest),
        .master_read(master_read), .master_address(master_address),
        .master_burstcount(master_burstcount), .master_byteenable(master_byteenable),
        .master_readdata(master_readdata), .master_waitrequest(master_waitrequest),
        .master_readdatavalid(master_readdatavalid), .irq(irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // "123456789" lives at 0x1000; everything else is a fixed address-derived pattern.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] v;
        if (a >= 32'h1000 && a < 32'h1009) v = 8'h31 + 8'(a - 32'h1000);
        else v = (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h5A;
        return v;
    endfunction

    function automatic logic [31:0] crc_ref(input logic [31:0] base, input int len,
                                            input logic [31:0] init, input logic xo);
        logic [31:0] c;
        logic [7:0]  d;
        c = init;
        for (int n = 0; n < len; n++) begin
            d = mem_byte(base + 32'(n));
            for (int i = 7; i >= 0; i--) begin
                if (c[31] ^ d[i]) c = (c << 1) ^ 32'h04C11DB7;
                else c = c << 1;
            end
        end
        return xo ? ~c : c;
    endfunction

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Responder and monitor: all decisions at negedge, consumed by the DUT at the following posedge.
    logic [31:0] req_addr[$];
    int          req_cnt[$];
    int          req_hold[$];
    logic        req_stable[$];
    logic [31:0] beat_addr = '0, first_addr = '0;
    logic [3:0]  first_cnt = '0;
    logic        stable = 1'b1, irq_prev = 1'b0;
    int pending = 0, hold = 0, beat_cnt = 0, read_cycles = 0;
    int stall_idx = -1, stall_len = 0, last_beat_edge = 0, irq_rise_edge = -1;

    initial begin
        master_waitrequest   = 1'b0;
        master_readdatavalid = 1'b0;
        master_readdata      = '0;
        forever begin
            @(negedge clk);
            if (irq && !irq_prev) irq_rise_edge = cyc;
            irq_prev = irq;
            if (reset) begin
                master_readdatavalid = 1'b0;
                if (pending > 2) pending = 2;
            end else if (pending > 0) begin
                master_readdatavalid = 1'b1;
                for (int i = 0; i < 8; i++) master_readdata[i*8 +: 8] = mem_byte(beat_addr + 32'(i));
                beat_addr      = beat_addr + 32'd8;
                pending        = pending - 1;
                beat_cnt       = beat_cnt + 1;
                last_beat_edge = cyc + 1;
            end else begin
                master_readdatavalid = 1'b0;
            end
            if (master_read) begin
                read_cycles++;
                if (hold == 0) begin
                    first_addr = master_address;
                    first_cnt  = master_burstcount;
                    stable     = 1'b1;
                end else if (master_address !== first_addr || master_burstcount !== first_cnt) begin
                    stable = 1'b0;
                end
                hold++;
                if (req_addr.size() == stall_idx && hold <= stall_len) begin
                    master_waitrequest = 1'b1;
                end else begin
                    master_waitrequest = 1'b0;
                    req_addr.push_back(first_addr);
                    req_cnt.push_back(int'(first_cnt));
                    req_hold.push_back(hold);
                    req_stable.push_back(stable);
                    beat_addr = first_addr;
                    pending   = int'(first_cnt);
                    hold      = 0;
                end
            end else begin
                master_waitrequest = 1'b0;
            end
        end
    end

    task automatic ctrl_wr(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        ctrl_write = 1'b1; ctrl_address = {29'd0, a}; ctrl_writedata = d;
        @(posedge clk); #1;
        ctrl_write = 1'b0;
    endtask

    task automatic ctrl_rd(input logic [2:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        ctrl_read = 1'b1; ctrl_address = {29'd0, a};
        @(posedge clk); #1;
        ctrl_read = 1'b0;
        d = ctrl_readdata;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        int n;
        n = 0;
        do begin
            ctrl_rd(3'd1, s);
            n++;
        end while (s[0] && n < 300);
        if (s[0]) chk({tag, "_idle_timeout"}, s[0], 1'b0);
    endtask

    task automatic wait_beats(input string tag, input int target);
        int n;
        n = 0;
        while (beat_cnt < target && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (beat_cnt < target) chk({tag, "_beat_timeout"}, 64'(beat_cnt), 64'(target));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    logic [31:0] rd;
    int n0, b0, rc;

    initial begin
        reset = 1'b1; ctrl_write = 1'b0; ctrl_read = 1'b0;
        ctrl_address = '0; ctrl_writedata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_master_read", master_read, 1'b0);
        chk("rst_irq", irq, 1'b0);
        ctrl_rd(3'd1, rd); chk("rst_status", rd, 32'h0);
        ctrl_rd(3'd5, rd); chk("rst_seed", rd, 32'hFFFFFFFF);
        ctrl_rd(3'd4, rd); chk("rst_result", rd, 32'h0);
        ctrl_rd(3'd0, rd); chk("rst_ctrl", rd, 32'h0);
        ctrl_rd(3'd7, rd); chk("unmapped", rd, 32'h0);

        // 1: "123456789", tail masking in second beat
        ctrl_wr(3'd2, 32'h1000);
        ctrl_wr(3'd3, 32'd9);
        n0 = req_addr.size();
        irq_rise_edge = -1;
        ctrl_wr(3'd0, 32'h3);
        wait_idle("t1");
        chk("t1_nreq", 64'(req_addr.size() - n0), 64'd1);
        chk("t1_addr", req_addr[n0], 32'h1000);
        chk("t1_bcnt", 64'(req_cnt[n0]), 64'd2);
        ctrl_rd(3'd4, rd); chk("t1_result", rd, 32'h0376E6E7);
        ctrl_rd(3'd1, rd); chk("t1_status", rd, 32'h2);
        chk("t1_irq", irq, 1'b1);
        chk("t1_irq_lat", 64'(irq_rise_edge - last_beat_edge), 64'd2);

        // 2: same with final XOR
        ctrl_wr(3'd1, 32'h6);
        ctrl_wr(3'd0, 32'h7);
        wait_idle("t2");
        ctrl_rd(3'd4, rd); chk("t2_result", rd, 32'hFC891918);

        // 3: two bursts, first stalled 3 cycles
        ctrl_wr(3'd1, 32'h6);
        ctrl_wr(3'd2, 32'h2000);
        ctrl_wr(3'd3, 32'd80);
        n0 = req_addr.size();
        b0 = beat_cnt;
        stall_idx = n0; stall_len = 3;
        ctrl_wr(3'd0, 32'h1);
        wait_idle("t3");
        stall_idx = -1;
        chk("t3_nreq", 64'(req_addr.size() - n0), 64'd2);
        chk("t3_addr0", req_addr[n0], 32'h2000);
        chk("t3_bcnt0", 64'(req_cnt[n0]), 64'd8);
        chk("t3_hold0", 64'(req_hold[n0]), 64'd4);
        chk("t3_stable0", req_stable[n0], 1'b1);
        chk("t3_addr1", req_addr[n0+1], 32'h2040);
        chk("t3_bcnt1", 64'(req_cnt[n0+1]), 64'd2);
        chk("t3_beats", 64'(beat_cnt - b0), 64'd10);
        ctrl_rd(3'd4, rd); chk("t3_result", rd, crc_ref(32'h2000, 80, 32'hFFFFFFFF, 1'b0));
        ctrl_rd(3'd1, rd); chk("t3_status", rd, 32'h2);
        chk("t3_irq_off", irq, 1'b0);

        // 4: zero length and misaligned address
        ctrl_wr(3'd1, 32'h6);
        ctrl_wr(3'd5, 32'hA5A50F0F);
        ctrl_wr(3'd3, 32'd0);
        rc = read_cycles;
        ctrl_wr(3'd0, 32'h1);
        ctrl_rd(3'd1, rd); chk("t4_len0_status", rd, 32'h6);
        ctrl_rd(3'd4, rd); chk("t4_len0_result", rd, 32'hA5A50F0F);
        ctrl_wr(3'd1, 32'h6);
        ctrl_rd(3'd1, rd); chk("t4_w1c", rd, 32'h0);
        ctrl_wr(3'd2, 32'h1004);
        ctrl_wr(3'd3, 32'd9);
        ctrl_wr(3'd0, 32'h5);
        ctrl_rd(3'd1, rd); chk("t4_mis_status", rd, 32'h6);
        ctrl_rd(3'd4, rd); chk("t4_mis_result", rd, 32'h5A5AF0F0);
        chk("t4_no_read", 64'(read_cycles - rc), 64'd0);

        // 5: abort after the 3rd of 8 beats, then restart
        ctrl_wr(3'd1, 32'h6);
        ctrl_wr(3'd5, 32'hFFFFFFFF);
        ctrl_wr(3'd2, 32'h3000);
        ctrl_wr(3'd3, 32'd64);
        n0 = req_addr.size();
        b0 = beat_cnt;
        ctrl_wr(3'd0, 32'h1);
        wait_beats("t5a", b0 + 2);
        ctrl_wr(3'd0, 32'h8);
        wait_beats("t5b", b0 + 8);
        repeat (3) @(posedge clk);
        ctrl_rd(3'd1, rd); chk("t5_status", rd, 32'h4);
        ctrl_rd(3'd4, rd); chk("t5_result_kept", rd, 32'h5A5AF0F0);
        chk("t5_nreq", 64'(req_addr.size() - n0), 64'd1);
        ctrl_wr(3'd0, 32'h1);
        wait_idle("t5r");
        chk("t5r_nreq", 64'(req_addr.size() - n0), 64'd2);
        ctrl_rd(3'd4, rd); chk("t5r_result", rd, crc_ref(32'h3000, 64, 32'hFFFFFFFF, 1'b0));
        ctrl_rd(3'd1, rd); chk("t5r_status", rd, 32'h2);

        // 6: reset mid-DATA, stray beats afterwards
        ctrl_wr(3'd1, 32'h6);
        ctrl_wr(3'd5, 32'h11223344);
        b0 = beat_cnt;
        ctrl_wr(3'd0, 32'h3);
        wait_beats("t6", b0 + 2);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        rc = read_cycles;
        n0 = req_addr.size();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t6_master_read", master_read, 1'b0);
        chk("t6_irq", irq, 1'b0);
        ctrl_rd(3'd1, rd); chk("t6_status", rd, 32'h0);
        ctrl_rd(3'd5, rd); chk("t6_seed", rd, 32'hFFFFFFFF);
        ctrl_rd(3'd0, rd); chk("t6_ctrl", rd, 32'h0);
        chk("t6_no_read", 64'(read_cycles - rc), 64'd0);
        ctrl_wr(3'd2, 32'h1000);
        ctrl_wr(3'd3, 32'd9);
        ctrl_wr(3'd0, 32'h1);
        wait_idle("t6r");
        chk("t6r_nreq", 64'(req_addr.size() - n0), 64'd1);
        ctrl_rd(3'd4, rd); chk("t6r_result", rd, 32'h0376E6E7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
